// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator (two clocks per pixel): position counters plus registered decodes.
// Define VGA_TIMING_ALIGN_EN to delay the decodes by PIPE_DELAY cycles to match the display driver.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 1280,
  parameter int H_FP        = 32,
  parameter int H_SYNC      = 192,
  parameter int H_BP        = 96,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE_DELAY  = 2
) (
  input  logic        clk,
  input  logic        clear,
  output logic [10:0] XPos,
  output logic [9:0]  YPos,
  output logic        Valid,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Decode bundle order: {valid, hsync, vsync, frame_start}
  localparam logic [3:0] DEC_IDLE = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  logic [10:0] x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic [3:0]  dec_reg, dec_next;
  logic        x_wrap;

  // Decodes are taken from the next counter values so the registered
  // result lines up with the registered position.
  always_comb begin
    x_wrap = (x_reg == H_MAX);
    x_next = x_wrap ? 11'd0 : x_reg + 11'd1;
    y_next = y_reg;
    if (x_wrap) begin
      y_next = (y_reg == V_MAX) ? 10'd0 : y_reg + 10'd1;
    end
    dec_next[3] = (x_next < H_VIS) && (y_next < V_VIS);
    dec_next[2] = ((x_next >= H_SYNC_BEG) && (x_next < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_next[1] = ((y_next >= V_SYNC_BEG) && (y_next < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_next[0] = (x_next == 11'd0) && (y_next == 10'd0);
  end

  // Reset parks the counters on the last position so the first edge lands on (0,0).
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      x_reg   <= H_MAX;
      y_reg   <= V_MAX;
      dec_reg <= DEC_IDLE;
    end else begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      dec_reg <= dec_next;
    end
  end

  assign XPos = x_reg;
  assign YPos = y_reg;

`ifdef VGA_TIMING_ALIGN_EN
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
      logic [3:0] stage_reg;
      logic [3:0] stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = dec_reg;
      end else begin : g_chain
        assign stage_in = g_stage[gi-1].stage_reg;
      end
      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          stage_reg <= DEC_IDLE;
        end else begin
          stage_reg <= stage_in;
        end
      end
    end
  endgenerate
  assign {Valid, vga_hsync, vga_vsync, frame_start} = g_stage[PIPE_DELAY-1].stage_reg;
`else
  assign {Valid, vga_hsync, vga_vsync, frame_start} = dec_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line-level timing, a shrunken
// instance for frame-level behaviour; both checked cycle by cycle against a queue of expected values.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_ALIGN_EN
  localparam int PD = 2;
`else
  localparam int PD = 0;
`endif

  // Index 0: default geometry, index 1: small geometry
  localparam int HV[2] = '{1280, 16};
  localparam int HF[2] = '{32, 2};
  localparam int HS[2] = '{192, 4};
  localparam int HB[2] = '{96, 3};
  localparam int VV[2] = '{480, 6};
  localparam int VF[2] = '{10, 2};
  localparam int VS[2] = '{2, 2};
  localparam int VB[2] = '{33, 3};

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        v0, v1, hs0, hs1, vs0, vs1, fs0, fs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .clear(clear), .XPos(x0), .YPos(y0), .Valid(v0),
    .vga_hsync(hs0), .vga_vsync(vs0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_small (
    .clk(clk), .clear(clear), .XPos(x1), .YPos(y1), .Valid(v1),
    .vga_hsync(hs1), .vga_vsync(vs1), .frame_start(fs1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs t edges after reset release (t<0 means held in reset).
  function automatic obs_t expect_at(input int t, input int k);
    obs_t o;
    int ht, vt, td, xd, yd;
    ht = HV[k] + HF[k] + HS[k] + HB[k];
    vt = VV[k] + VF[k] + VS[k] + VB[k];
    if (t < 0) begin
      o.x = 11'(ht - 1);
      o.y = 10'(vt - 1);
    end else begin
      o.x = 11'(t % ht);
      o.y = 10'((t / ht) % vt);
    end
    td = t - PD;
    if (td < 0) begin
      {o.v, o.hs, o.vs, o.fs} = 4'b0110;
    end else begin
      xd = td % ht;
      yd = (td / ht) % vt;
      o.v  = (xd < HV[k]) && (yd < VV[k]);
      o.hs = !((xd >= HV[k] + HF[k]) && (xd < HV[k] + HF[k] + HS[k]));
      o.vs = !((yd >= VV[k] + VF[k]) && (yd < VV[k] + VF[k] + VS[k]));
      o.fs = (xd == 0) && (yd == 0);
    end
    return o;
  endfunction

  obs_t q0[$];
  obs_t q1[$];
  int   t_cnt = -1;

  always @(posedge clk) begin
    if (clear) t_cnt = -1;
    else t_cnt++;
    q0.push_back(expect_at(t_cnt, 0));
    q1.push_back(expect_at(t_cnt, 1));
  end

  always @(negedge clk) begin
    obs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("sb_dflt", 32'({x0, y0, v0, hs0, vs0, fs0}), 32'(e));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("sb_small", 32'({x1, y1, v1, hs1, vs1, fs1}), 32'(e));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, 32'(x0), 32'd1599);
    check({tag, "_y"}, 32'(y0), 32'd524);
    check({tag, "_valid"}, 32'(v0), 32'd0);
    check({tag, "_hsync"}, 32'(hs0), 32'd1);
    check({tag, "_vsync"}, 32'(vs0), 32'd1);
    check({tag, "_fs"}, 32'(fs0), 32'd0);
    check({tag, "_small_xy"}, 32'({x1, y1}), 32'({11'd24, 10'd12}));
  endtask

  task automatic check_first_edge(input string tag);
    check({tag, "_x"}, 32'(x0), 32'd0);
    check({tag, "_y"}, 32'(y0), 32'd0);
    check({tag, "_valid"}, 32'(v0), 32'(PD == 0));
    check({tag, "_fs"}, 32'(fs0), 32'(PD == 0));
  endtask

  initial begin
    int valid_cnt, hs_cnt, valid_fall, hs_fall, hs_rise;
    int f1, f2, vs_small, v_small;
    logic pv, phs;
    bit found;

    // Reset for 5 cycles, then release
    clear = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("rst");
    clear = 1'b0;
    @(negedge clk);
    check_first_edge("first");

    // One full line on the default instance, small-frame periods alongside
    valid_cnt = 0; hs_cnt = 0; valid_fall = -1; hs_fall = -1; hs_rise = -1;
    f1 = -1; f2 = -1; vs_small = 0; v_small = 0;
    pv = v0; phs = hs0;
    for (int i = 0; i < 1600; i++) begin
      if (v0) valid_cnt++;
      if (!hs0) hs_cnt++;
      if (pv && !v0 && valid_fall < 0) valid_fall = int'(x0);
      if (phs && !hs0 && hs_fall < 0) hs_fall = int'(x0);
      if (!phs && hs0 && hs_rise < 0) hs_rise = int'(x0);
      pv = v0; phs = hs0;
      if (fs1) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (f1 >= 0 && f2 < 0) begin
        if (!vs1) vs_small++;
        if (v1) v_small++;
      end
      @(negedge clk);
    end
    check("line_valid_cnt", 32'(valid_cnt), 32'd1280);
    check("line_hsync_cnt", 32'(hs_cnt), 32'd192);
    check("valid_fall_x", 32'(valid_fall), 32'(1280 + PD));
    check("hsync_fall_x", 32'(hs_fall), 32'(1312 + PD));
    check("hsync_rise_x", 32'(hs_rise), 32'(1504 + PD));
    check("wrap_x", 32'(x0), 32'd0);
    check("wrap_y", 32'(y0), 32'd1);
    check("small_frame_period", 32'(f2 - f1), 32'd325);
    check("small_vsync_cnt", 32'(vs_small), 32'd50);
    check("small_valid_cnt", 32'(v_small), 32'd96);

    // Mid-frame asynchronous reset at XPos=700
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (x0 == 11'd700) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_x700", 32'(found), 32'd1);
    #2 clear = 1'b1;
    #1 check_reset_values("async");
    repeat (3) @(negedge clk);
    check_reset_values("held");
    clear = 1'b0;
    @(negedge clk);
    check_first_edge("restart");

    // Let the scoreboard cover the simultaneous wrap on the small instance again
    repeat (700) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
